// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle for shift_add_multiplier. SIGNED_MUL_EN adds the i_signed request qualifier.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 32
);
  // Handshake: i_start is sampled on a rising edge while the block is idle or
  // in its one-cycle done state. i_a/i_b (and i_signed) are captured only on
  // that accepting edge. o_busy is high for the WIDTH iteration cycles, and
  // o_done pulses for one cycle with o_product valid. o_product holds until the
  // next accepted i_start.
  logic                 i_start;
  logic [WIDTH-1:0]     i_a;
  logic [WIDTH-1:0]     i_b;
`ifdef SIGNED_MUL_EN
  logic                 i_signed;
`endif
  logic                 o_busy;
  logic                 o_done;
  logic [2*WIDTH-1:0]   o_product;

  modport master (
`ifdef SIGNED_MUL_EN
    output i_signed,
`endif
    output i_start, i_a, i_b,
    input  o_busy, o_done, o_product
  );

  modport slave (
`ifdef SIGNED_MUL_EN
    input  i_signed,
`endif
    input  i_start, i_a, i_b,
    output o_busy, o_done, o_product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH in WIDTH iteration cycles.
// Define SIGNED_MUL_EN for two's-complement operation selected per request by i_signed.
module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  shift_add_multiplier_if.slave  bus,
  output logic [1:0]             o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_prod;
  logic                 r_carry;
  logic [CW-1:0]        r_count;
  logic                 r_neg;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_neg_in;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_shifted;

  // Operands enter the datapath as magnitudes; the sign is reapplied on the last iteration.
  always_comb begin
    w_a_mag  = bus.i_a;
    w_b_mag  = bus.i_b;
    w_neg_in = 1'b0;
`ifdef SIGNED_MUL_EN
    if (bus.i_signed) begin
      if (bus.i_a[WIDTH-1]) w_a_mag = -bus.i_a;
      if (bus.i_b[WIDTH-1]) w_b_mag = -bus.i_b;
      w_neg_in = bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1];
    end
`endif
  end

  // One iteration: conditional add into the high half, then shift {carry, product} right.
  always_comb begin
    w_sum     = {r_carry, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_mcand : '0)};
    w_shifted = {w_sum, r_prod[WIDTH-1:1]};
    w_last    = (r_count == CW'(1));
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        if (bus.i_start) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_neg   <= 1'b0;
    end else if (w_accept) begin
      r_mcand <= w_a_mag;
      r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
      r_carry <= 1'b0;
      r_count <= CW'(WIDTH);
      r_neg   <= w_neg_in;
    end else if (r_state == S_RUN) begin
      r_carry <= 1'b0;
      r_count <= r_count - CW'(1);
      r_prod  <= (w_last && r_neg) ? -w_shifted : w_shifted;
    end
  end

  assign bus.o_busy    = (r_state == S_RUN);
  assign bus.o_done    = (r_state == S_DONE);
  assign bus.o_product = r_prod;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized self-checking bench for shift_add_multiplier against a plain-arithmetic product model.
module tb_shift_add_multiplier;

  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q[$];

`ifdef SIGNED_MUL_EN
  logic drv_signed = 1'b0;
`endif

  shift_add_multiplier_if #(.WIDTH(W)) bus();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_umul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] wa, wb;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    return wa * wb;
  endfunction

`ifdef SIGNED_MUL_EN
  function automatic logic [2*W-1:0] ref_smul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction
`endif

  // ---------------- driver ----------------
  // Presents one request, releases i_start after the accepting edge and follows
  // the run to its done pulse. lat counts edges including the accepting one.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_n, output logic [2*W-1:0] prod);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
`ifdef SIGNED_MUL_EN
    bus.i_signed = drv_signed;
`endif
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    lat    = 1;
    busy_n = bus.o_busy ? 1 : 0;
    while (!bus.o_done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (bus.o_busy) busy_n++;
    end
    prod = bus.o_product;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
`ifdef SIGNED_MUL_EN
    bus.i_signed = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
    n_checks++; if (bus.o_product !== '0) begin n_fail++; $display("FAIL reset_product: got %h want 0", bus.o_product); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, busy_n;
    logic [2*W-1:0] prod;
    run_op(32'd3, 32'd5, lat, busy_n, prod);
    n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, W + 1); end
    n_checks++; if (busy_n !== W) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want %0d", busy_n, W); end
    n_checks++; if (prod !== 64'h0000_0000_0000_000F) begin n_fail++; $display("FAIL basic_product: got %h want f", prod); end
    @(posedge clk); #1;
    n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse_width: got %b want 0", bus.o_done); end
    n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b want 0", bus.o_busy); end
    bus.i_a = $urandom;
    bus.i_b = $urandom;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (bus.o_product !== 64'hF) begin n_fail++; $display("FAIL basic_product_hold: got %h want f", bus.o_product); end
  endtask

  task automatic test_corners();
    logic [W-1:0] ta[5];
    logic [W-1:0] tb[5];
    int lat, busy_n;
    logic [2*W-1:0] prod, exp_v;
    ta = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678, 32'h0000_0001, 32'h8000_0000};
    tb = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0002};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ref_umul(ta[i], tb[i]));
      run_op(ta[i], tb[i], lat, busy_n, prod);
      exp_v = exp_q.pop_front();
      n_checks++; if (prod !== exp_v) begin n_fail++; $display("FAIL corner_product[%0d]: %h*%h got %h want %h", i, ta[i], tb[i], prod, exp_v); end
      n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL corner_latency[%0d]: got %0d want %0d", i, lat, W + 1); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    int lat, busy_n;
    logic [2*W-1:0] prod, exp_v;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = (i % 4 == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
      exp_q.push_back(ref_umul(a, b));
      run_op(a, b, lat, busy_n, prod);
      exp_v = exp_q.pop_front();
      n_checks++; if (prod !== exp_v) begin n_fail++; $display("FAIL random_product[%0d]: %h*%h got %h want %h", i, a, b, prod, exp_v); end
    end
  endtask

  task automatic test_start_ignored();
    int done_cnt, done_edge;
    logic [2*W-1:0] prod;
    done_cnt  = 0;
    done_edge = 0;
    prod      = '0;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = 32'd3;
    bus.i_b     = 32'd5;
    @(posedge clk); #1;
    for (int e = 1; e <= 45; e++) begin
      if (e == 10) begin
        bus.i_start = 1'b1;
        bus.i_a     = 32'd7;
        bus.i_b     = 32'd7;
      end else begin
        bus.i_start = 1'b0;
        bus.i_a     = $urandom;
        bus.i_b     = $urandom;
      end
      @(posedge clk); #1;
      if (bus.o_done) begin
        done_cnt++;
        done_edge = e + 1;
        prod      = bus.o_product;
      end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (done_edge !== W + 1) begin n_fail++; $display("FAIL ignore_latency: got %0d want %0d", done_edge, W + 1); end
    n_checks++; if (prod !== 64'hF) begin n_fail++; $display("FAIL ignore_product: got %h want f", prod); end
    n_checks++; if (bus.o_product !== 64'hF) begin n_fail++; $display("FAIL ignore_product_hold: got %h want f", bus.o_product); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [2*W-1:0] exp1, exp2;
    exp_q.push_back(ref_umul(32'd11, 32'd13));
    exp_q.push_back(ref_umul(32'd2, 32'd9));
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = 32'd11;
    bus.i_b     = 32'd13;
    @(posedge clk); #1;
    bus.i_a = 32'd2;
    bus.i_b = 32'd9;
    lat = 1;
    while (!bus.o_done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    exp1 = exp_q.pop_front();
    n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, W + 1); end
    n_checks++; if (bus.o_product !== exp1) begin n_fail++; $display("FAIL b2b_first_product: got %h want %h", bus.o_product, exp1); end
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    n_checks++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap_busy: got %b want 1", bus.o_busy); end
    n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_cleared: got %b want 0", bus.o_done); end
    lat = 1;
    while (!bus.o_done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    exp2 = exp_q.pop_front();
    n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, W + 1); end
    n_checks++; if (bus.o_product !== exp2) begin n_fail++; $display("FAIL b2b_second_product: got %h want %h", bus.o_product, exp2); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    int lat, busy_n, done_cnt;
    logic [2*W-1:0] prod;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = 32'd3;
    bus.i_b     = 32'd5;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.o_busy); end
    n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", bus.o_done); end
    n_checks++; if (bus.o_product !== '0) begin n_fail++; $display("FAIL midrst_product: got %h want 0", bus.o_product); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (bus.o_done) done_cnt++;
    end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt); end
    run_op(32'd6, 32'd7, lat, busy_n, prod);
    n_checks++; if (prod !== 64'h2A) begin n_fail++; $display("FAIL midrst_next_product: got %h want 2a", prod); end
    n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL midrst_next_latency: got %0d want %0d", lat, W + 1); end
  endtask

`ifdef SIGNED_MUL_EN
  task automatic test_signed();
    logic [W-1:0] ta[5];
    logic [W-1:0] tb[5];
    logic         ts[5];
    logic [W-1:0] a, b;
    int lat, busy_n;
    logic [2*W-1:0] prod, exp_v;
    ta = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    tb = '{32'd5,         32'd5,         32'h8000_0000, 32'd1,         32'h8000_0000};
    ts = '{1'b1,          1'b0,          1'b1,          1'b1,          1'b1};
    for (int i = 0; i < 5; i++) begin
      drv_signed = ts[i];
      exp_q.push_back(ts[i] ? ref_smul(ta[i], tb[i]) : ref_umul(ta[i], tb[i]));
      run_op(ta[i], tb[i], lat, busy_n, prod);
      exp_v = exp_q.pop_front();
      n_checks++; if (prod !== exp_v) begin n_fail++; $display("FAIL signed_table[%0d]: %h*%h s=%b got %h want %h", i, ta[i], tb[i], ts[i], prod, exp_v); end
      n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL signed_latency[%0d]: got %0d want %0d", i, lat, W + 1); end
    end
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      drv_signed = 1'b1;
      exp_q.push_back(ref_smul(a, b));
      run_op(a, b, lat, busy_n, prod);
      exp_v = exp_q.pop_front();
      n_checks++; if (prod !== exp_v) begin n_fail++; $display("FAIL signed_random[%0d]: %h*%h got %h want %h", i, a, b, prod, exp_v); end
    end
    drv_signed = 1'b0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
`ifdef SIGNED_MUL_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
